// File: rtl/dll_shift_decoder_pkg.sv
// Shared DLL normalized-number constants and the position clamp helper.
// Used by the shift decoder; the priority encoder uses the same widths.
package dll_shift_decoder_pkg;

  localparam int DLL_POS_WIDTH   = 5;
  localparam int DLL_VALUE_WIDTH = 19;
  localparam int DLL_POS_MIN     = 7;
  localparam int DLL_MANT_WIDTH  = 6;
  // Guard bits below bit 0 let the x4 coarse shift round down without losing bits
  localparam int DLL_GUARD_BITS  = 3;
  localparam int DLL_SHIFT_WIDTH = 6;

  typedef struct packed {
    logic [DLL_POS_WIDTH-1:0] pos;
    logic                     sat;
    logic                     clamp;
  } pos_info_t;

  function automatic pos_info_t dll_clamp_pos(
    input logic [DLL_POS_WIDTH-1:0] pos,
    input logic [DLL_POS_WIDTH-1:0] lo,
    input logic [DLL_POS_WIDTH-1:0] hi
  );
    pos_info_t r;
    r.sat   = (pos > hi);
    r.clamp = (pos < lo);
    if (r.sat) begin
      r.pos = hi;
    end else if (r.clamp) begin
      r.pos = lo;
    end else begin
      r.pos = pos;
    end
    return r;
  endfunction

endpackage

// File: rtl/dll_shift_decoder_shift_stage.sv
// Registered signed shifter: left for positive shift, right for negative,
// shift amount counted in units of GRAN bits; output keeps the top OUT_W bits.
module dll_shift_stage #(
  parameter int WIDTH = 22,
  parameter int OUT_W = 22,
  parameter int GRAN  = 1,
  parameter int SH_W  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [WIDTH-1:0]       in_data,
  input  logic signed [SH_W-1:0] in_shift,
  output logic [OUT_W-1:0]       out_data
);

  logic [SH_W-1:0]  mag_s;
  logic [7:0]       amt_s;
  logic [WIDTH-1:0] shifted_s;

  // Magnitude/direction decode and the shift itself
  always_comb begin
    if (in_shift[SH_W-1]) begin
      mag_s = $unsigned(-in_shift);
    end else begin
      mag_s = $unsigned(in_shift);
    end
    amt_s = 8'(mag_s) * 8'(GRAN);
    if (in_shift[SH_W-1]) begin
      shifted_s = in_data >> amt_s;
    end else begin
      shifted_s = in_data << amt_s;
    end
  end

  // Result register, loaded only when the pipeline stage advances
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= OUT_W'(shifted_s >> (WIDTH - OUT_W));
    end
  end

endmodule

// File: rtl/dll_shift_decoder.sv
// Two-stage valid/ready decoder rebuilding a DLL magnitude from mantissa + position.
// Define DLL_DEC_ROUND_EN to add a half-LSB reconstruction bias below the mantissa.
module dll_shift_decoder
  import dll_shift_decoder_pkg::*;
#(
  parameter int MANT_WIDTH = DLL_MANT_WIDTH,
  parameter int OUT_WIDTH  = DLL_VALUE_WIDTH,
  parameter int POS_MIN    = DLL_POS_MIN
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MANT_WIDTH-1:0]    in_mant,
  input  logic [DLL_POS_WIDTH-1:0] in_pos,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out_value,
  output logic                     out_sat,
  output logic                     out_clamp
);

  localparam int WORD_W = OUT_WIDTH + DLL_GUARD_BITS;
`ifdef DLL_DEC_ROUND_EN
  localparam logic RND_BIT = 1'b1;
`else
  localparam logic RND_BIT = 1'b0;
`endif

  pos_info_t                   pinfo_s;
  logic signed [DLL_SHIFT_WIDTH-1:0] shift_s;
  logic [WORD_W-1:0]           coarse_in_s;
  logic signed [3:0]           coarse_sh_s;
  logic [1:0]                  fine_sh_s;
  logic [WORD_W-1:0]           coarse_q_s;
  logic                        s1_valid_r;
  logic [1:0]                  s1_fine_r;
  logic                        s1_sat_r;
  logic                        s1_clamp_r;
  logic                        s2_adv_s;
  logic                        s2_load_s;
  logic                        accept_s;

  assign s2_adv_s  = !out_valid || out_ready;
  assign s2_load_s = s2_adv_s && s1_valid_r;
  assign in_ready  = !s1_valid_r || s2_adv_s;
  assign accept_s  = in_valid && in_ready;

  // Clamp position and split the signed shift; saturation injects an all-ones word
  always_comb begin
    pinfo_s = dll_clamp_pos(in_pos, DLL_POS_WIDTH'(POS_MIN), DLL_POS_WIDTH'(OUT_WIDTH - 1));
    shift_s = signed'(DLL_SHIFT_WIDTH'(pinfo_s.pos)) - signed'(DLL_SHIFT_WIDTH'(MANT_WIDTH - 1));
    if (pinfo_s.sat) begin
      coarse_in_s = '1;
      coarse_sh_s = 4'sd0;
      fine_sh_s   = 2'd0;
    end else begin
      // Mantissa sits above the guard bits; the rounding bit rides just below its LSB
      coarse_in_s = WORD_W'({in_mant, RND_BIT, 2'b00});
      coarse_sh_s = shift_s[5:2];
      fine_sh_s   = shift_s[1:0];
    end
  end

  dll_shift_stage #(
    .WIDTH (WORD_W),
    .OUT_W (WORD_W),
    .GRAN  (4),
    .SH_W  (4)
  ) u_coarse (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept_s),
    .in_data  (coarse_in_s),
    .in_shift (coarse_sh_s),
    .out_data (coarse_q_s)
  );

  dll_shift_stage #(
    .WIDTH (WORD_W),
    .OUT_W (OUT_WIDTH),
    .GRAN  (1),
    .SH_W  (3)
  ) u_fine (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (s2_load_s),
    .in_data  (coarse_q_s),
    .in_shift (signed'({1'b0, s1_fine_r})),
    .out_data (out_value)
  );

  // Stage-1 valid and side-band registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_fine_r  <= 2'd0;
      s1_sat_r   <= 1'b0;
      s1_clamp_r <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_r <= in_valid;
      end
      if (accept_s) begin
        s1_fine_r  <= fine_sh_s;
        s1_sat_r   <= pinfo_s.sat;
        s1_clamp_r <= pinfo_s.clamp;
      end
    end
  end

  // Output valid and flag registers, held while downstream stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      out_clamp <= 1'b0;
    end else begin
      if (s2_adv_s) begin
        out_valid <= s1_valid_r;
      end
      if (s2_load_s) begin
        out_sat   <= s1_sat_r;
        out_clamp <= s1_clamp_r;
      end
    end
  end

endmodule

// File: doc/dll_shift_decoder.md
# dll_shift_decoder

Inverse of the DLL leading-one priority encoder. Takes a short mantissa and a leading-one position (5-bit, same encoding the encoder emits: 7..18) and rebuilds the 19-bit fixed-point magnitude by placing the mantissa MSB at that bit. It sits on the DLL loop-filter output path, where the discriminator result is carried in normalized form. It converts that form back to full width for the code NCO rate word. It is a two-stage valid/ready pipeline, split coarse/fine for timing like the encoder.

## Interface
- MANT_WIDTH, 6, mantissa width (2..12)
- OUT_WIDTH, 19, reconstructed value width
- POS_MIN, 7, smallest legal position; matches encoder's "below bit 8" code
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  mantissa/pos valid
- in_ready  output  1  stage 1 can accept
- in_mant  input  MANT_WIDTH  mantissa, MSB aligned to pos
- in_pos  input  5  leading-one bit index
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_value  output  OUT_WIDTH  reconstructed magnitude
- out_sat  output  1  in_pos > OUT_WIDTH-1; out_value saturated
- out_clamp  output  1  in_pos < POS_MIN; pos forced to POS_MIN

## Operation
- Transfer on each interface when valid && ready, same cycle.
- Stage 1 (on accept):
  - p = clamp(in_pos, POS_MIN, OUT_WIDTH-1); record sat/clamp flags.
  - shift = p - (MANT_WIDTH-1), signed 6-bit.
  - Coarse: mantissa zero-extended to OUT_WIDTH, shifted by shift with bits [1:0] cleared (left if positive, right if negative).
  - Register the coarse word, shift[1:0], and the flags.
- Stage 2: fine left shift by shift[1:0]; register out_value/out_sat/out_clamp.
- Mantissa bits shifted below bit 0 are truncated. Bits above OUT_WIDTH-1 cannot occur after the clamp.
- sat: out_value = all ones, regardless of mantissa.
- Mantissa MSB need not be 1; the block does no normalization check.
- Pipeline control:
  - Stage 2 advances when !out_valid || out_ready.
  - Stage 1 advances into stage 2 when stage 2 advances.
  - in_ready = !s1_valid || s2_advance (combinational from out_ready). Full throughput, no bubbles.
- Data registers load only on advance, so held values stay stable under stall.

## Timing
- Latency 2 cycles from accepted input to out_valid when unstalled; throughput 1/cycle.
- Reset (async, reset_n=0): s1_valid, out_valid, out_value, out_sat, out_clamp all 0; in_ready=1 one cycle after release.
- Reset mid-operation: in-flight data is discarded, nothing is emitted after release.
- Simultaneous stage-2 output accept and stage-1 refill is legal. No data is lost or duplicated.
- out_value/flags are held constant while out_valid && !out_ready.
- Order is strictly preserved.

## Configuration
- DLL_DEC_ROUND_EN defined:
  - Stage 2 ORs a 1 into the bit just below the mantissa LSB (half-LSB reconstruction bias), only when that bit index >= 0 and not sat.
  - This removes the truncation bias introduced by the encoder.
- Undefined: vacated bits are zero; no extra logic.

## Structure
- Shared package/header (global.vh): DLL_POS_WIDTH (5), DLL_VALUE_WIDTH (19), DLL_POS_MIN (7), DLL_MANT_WIDTH (6). These are shared with the priority encoder so both ends agree.
- One natural sub-module: dll_shift_stage. It is a registered shifter parameterized by shift granularity and instantiated twice (coarse x4, fine x1).

## Test plan
- Basic: mant=6'b101101, pos=12 -> out_value=19'h01680 after 2 cycles, sat=0, clamp=0. With DLL_DEC_ROUND_EN -> 19'h016C0.
- Top bit: mant=6'b100000, pos=18 -> 19'h40000. pos=25 -> 19'h7FFFF, out_sat=1.
- Clamp: mant=6'b101101, pos=3 -> treated as 7, out_value=19'h000B4, out_clamp=1.
- Round-trip: 1000 random 19-bit values >= 256 through the encoder, top 6 bits as mantissa -> decoder output equals input with bits below the mantissa zeroed (undef macro).
- Backpressure: stream 5 inputs, out_ready low cycles 2-4.
  - in_ready drops once both stages are full.
  - Outputs appear in order, none dropped or duplicated, out_value stable during stall.
- Reset mid-flight: assert reset_n=0 with both stages valid -> out_valid=0 immediately, no output after release; next input emerges 2 cycles after acceptance.
